// File: rtl/pwm_pulse_decoder_pkg.sv
// Shared PWM position mapping and decoder FSM encodings.
// The servo generator uses the same BASE/STEP/POS_MAX defaults.
package pwm_pulse_decoder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;
    localparam logic [1:0] ST_LOW  = 2'd2;

    localparam int unsigned PWM_BASE       = 50000;
    localparam int unsigned PWM_STEP       = 5000;
    localparam int unsigned PWM_POS_MAX    = 10;
    localparam int unsigned PWM_PERIOD_MAX = 1100000;

    function automatic logic [3:0] sat_inc(
        input logic [3:0] v,
        input logic [3:0] lim
    );
        return (v >= lim) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/pwm_pulse_decoder_if.sv
// Decoded PWM measurement bundle.
// The decoder drives it; control/display logic consumes it.
interface pwm_pulse_decoder_if #(
    parameter int CW = 20
);
    logic [3:0]    pos;
    logic [CW-1:0] width;
    logic [CW-1:0] period;
    logic          valid;
    logic          err_range;
    logic          err_timeout;

    modport master (
        output pos, width, period,
        output valid, err_range, err_timeout
    );

    modport slave (
        input pos, width, period,
        input valid, err_range, err_timeout
    );
endinterface

// File: rtl/pwm_edge_sync.sv
// Two-flop synchroniser for the PWM pin plus an edge-detect flop.
module pwm_edge_sync (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);
    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;
endmodule

// File: rtl/pwm_pulse_decoder.sv
// Measures PWM high time and period and maps high time to a
// position code without a divider.
module pwm_pulse_decoder
    import pwm_pulse_decoder_pkg::*;
#(
    parameter int          CW         = 20,
    parameter int unsigned BASE       = PWM_BASE,
    parameter int unsigned STEP       = PWM_STEP,
    parameter int unsigned POS_MAX    = PWM_POS_MAX,
    parameter int unsigned PERIOD_MAX = PWM_PERIOD_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic pwm_in,
    pwm_pulse_decoder_if.master res
);
    // Clamp the timeout so the counters can never wrap.
    localparam longint unsigned CFULL = (64'd1 << CW) - 64'd1;
    localparam logic [CW-1:0] PMAX =
        CW'((longint'(PERIOD_MAX) > CFULL) ? CFULL
                                           : longint'(PERIOD_MAX));
    localparam logic [CW-1:0] BASE_C  = CW'(BASE);
    localparam logic [CW-1:0] STEP_M1 = CW'(STEP - 1);
    localparam logic [CW-1:0] ONE     = CW'(1);
    localparam logic [3:0]    PMX     = 4'(POS_MAX);
    localparam logic [3:0]    POVER   = 4'(POS_MAX + 1);

    logic          level, rise, fall;
    logic [1:0]    state;
    logic [CW-1:0] hcnt, pcnt, scnt;
    logic [CW-1:0] hcnt_nxt;
    logic [3:0]    acc;
    logic          ge_base;

    logic [3:0]    pos_q;
    logic [CW-1:0] width_q, period_q;
    logic          valid_q, err_range_q, err_to_q;

    pwm_edge_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pwm_in),
        .level (level),
        .rise  (rise),
        .fall  (fall)
    );

    assign hcnt_nxt = hcnt + ONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            hcnt        <= '0;
            pcnt        <= '0;
            scnt        <= '0;
            acc         <= '0;
            ge_base     <= 1'b0;
            pos_q       <= '0;
            width_q     <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            err_range_q <= 1'b0;
            err_to_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (rise) begin
                        hcnt    <= ONE;
                        pcnt    <= ONE;
                        scnt    <= '0;
                        acc     <= '0;
                        ge_base <= (BASE_C <= ONE);
                        state   <= ST_HIGH;
                    end
                end
                ST_HIGH, ST_LOW: begin
                    if (rise) begin
                        width_q     <= hcnt;
                        period_q    <= pcnt;
                        valid_q     <= 1'b1;
                        err_to_q    <= 1'b0;
                        err_range_q <= ~ge_base | (acc > PMX);
                        pos_q       <= ~ge_base ? 4'd0
                                     : (acc > PMX) ? PMX : acc;
                        hcnt        <= ONE;
                        pcnt        <= ONE;
                        scnt        <= '0;
                        acc         <= '0;
                        ge_base     <= (BASE_C <= ONE);
                        state       <= ST_HIGH;
                    end else if (pcnt >= PMAX) begin
                        err_to_q <= 1'b1;
                        state    <= ST_IDLE;
                    end else begin
                        pcnt <= pcnt + ONE;
                        if (state == ST_HIGH && level) begin
                            hcnt <= hcnt_nxt;
                            // acc advances once every STEP cycles past BASE
                            if (hcnt_nxt == BASE_C) begin
                                ge_base <= 1'b1;
                                scnt    <= '0;
                                acc     <= '0;
                            end else if (ge_base) begin
                                if (scnt == STEP_M1) begin
                                    scnt <= '0;
                                    acc  <= sat_inc(acc, POVER);
                                end else begin
                                    scnt <= scnt + ONE;
                                end
                            end
                        end
                        if (state == ST_HIGH && fall)
                            state <= ST_LOW;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign res.pos         = pos_q;
    assign res.width       = width_q;
    assign res.period      = period_q;
    assign res.valid       = valid_q;
    assign res.err_range   = err_range_q;
    assign res.err_timeout = err_to_q;
endmodule
